// File: rtl/jpeg_haar_pipe.sv
// Pipelined N-point multi-level Haar butterfly with valid/ready on both sides and block row tagging.
// Optional macro HAAR_SCALE_EN: every stage result becomes (x+1)>>>1 to keep coefficients normalised.
module jpeg_haar_pipe #(
  parameter int IN_W      = 8,
  parameter int N         = 8,
  parameter int ROWS      = 8,
  parameter int LVL_SHIFT = 1,
  localparam int STAGES   = $clog2(N),
  localparam int OUT_W    = IN_W + STAGES,
  localparam int RIDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*IN_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*OUT_W-1:0]    out_data,
  output logic                  out_last,
  output logic [RIDX_W-1:0]     row_idx
);

  typedef logic signed [OUT_W-1:0] coef_t;

`ifdef HAAR_SCALE_EN
  // Arithmetic halving with round-half-up; keeps the full sum width until the shift.
  function automatic coef_t round_half(input logic signed [OUT_W:0] x);
    logic signed [OUT_W:0] y;
    y = x + {{OUT_W{1'b0}}, 1'b1};
    return y[OUT_W:1];
  endfunction
`endif

  function automatic coef_t bfly(input coef_t a, input coef_t b, input logic sub);
`ifdef HAAR_SCALE_EN
    logic signed [OUT_W:0] ax, bx;
    ax = a;
    bx = b;
    return round_half(sub ? ax - bx : ax + bx);
`else
    return sub ? a - b : a + b;
`endif
  endfunction

  coef_t             ent_p0   [N];
  coef_t             stage_in [STAGES][N];
  coef_t             nxt      [STAGES][N];
  coef_t             data_p   [STAGES][N];
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] rdy;

  // Entry: widen pixels to coefficient width, removing the level offset for unsigned input.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (LVL_SHIFT != 0)
        ent_p0[i] = $signed({{STAGES{1'b0}}, in_data[i*IN_W +: IN_W]})
                    - $signed(OUT_W'(2**(IN_W-1)));
      else
        ent_p0[i] = $signed({{STAGES{in_data[i*IN_W+IN_W-1]}}, in_data[i*IN_W +: IN_W]});
    end
  end

  // Stage s butterflies only the low band of width N>>s; the high band passes through.
  always_comb begin
    stage_in[0] = ent_p0;
    for (int s = 1; s < STAGES; s++)
      stage_in[s] = data_p[s-1];
    for (int s = 0; s < STAGES; s++) begin
      nxt[s] = stage_in[s];
      for (int i = 0; i < N/2; i++) begin
        if (i < ((N >> s) / 2)) begin
          nxt[s][i]                = bfly(stage_in[s][2*i], stage_in[s][2*i+1], 1'b0);
          nxt[s][((N >> s) / 2)+i] = bfly(stage_in[s][2*i], stage_in[s][2*i+1], 1'b1);
        end
      end
    end
  end

  // Ready ripples back from the output so a full pipe still accepts while draining.
  always_comb begin
    logic carry;
    carry  = out_ready;
    vin[0] = in_valid;
    for (int s = 1; s < STAGES; s++)
      vin[s] = vld_p[s-1];
    for (int s = STAGES-1; s >= 0; s--) begin
      carry  = !vld_p[s] || carry;
      rdy[s] = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p   <= '0;
      row_idx <= '0;
      for (int s = 0; s < STAGES; s++)
        for (int i = 0; i < N; i++)
          data_p[s][i] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          vld_p[s] <= vin[s];
          if (vin[s])
            data_p[s] <= nxt[s];
        end
      end
      if (out_valid && out_ready)
        row_idx <= (row_idx == RIDX_W'(ROWS-1)) ? '0 : row_idx + 1'b1;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[STAGES-1];
  assign out_last  = out_valid && (row_idx == RIDX_W'(ROWS-1));

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_data[i*OUT_W +: OUT_W] = data_p[STAGES-1][i];
  end

endmodule

// File: tb/tb_jpeg_haar_pipe.sv
// Bench for jpeg_haar_pipe: table vectors, level-shift instance, backpressure, block tagging and reset.
module tb_jpeg_haar_pipe;
  localparam int IN_W = 8, N = 8, ROWS = 8, OUT_W = 11, RW = 3;
  typedef logic [N*IN_W-1:0]  pix_t;
  typedef logic [N*OUT_W-1:0] coef_row_t;
  typedef struct packed { pix_t pix; coef_row_t exp; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready, out_last;
  pix_t in_data;
  coef_row_t out_data;
  logic [RW-1:0] row_idx;

  logic ls_in_valid, ls_in_ready, ls_out_valid, ls_out_ready, ls_out_last;
  pix_t ls_in_data;
  coef_row_t ls_out_data;
  logic [RW-1:0] ls_row_idx;

  jpeg_haar_pipe #(.IN_W(IN_W), .N(N), .ROWS(ROWS), .LVL_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .row_idx(row_idx));

  jpeg_haar_pipe #(.IN_W(IN_W), .N(N), .ROWS(ROWS), .LVL_SHIFT(1)) dut_ls (
    .clk(clk), .rst_n(rst_n), .in_valid(ls_in_valid), .in_ready(ls_in_ready), .in_data(ls_in_data),
    .out_valid(ls_out_valid), .out_ready(ls_out_ready), .out_data(ls_out_data),
    .out_last(ls_out_last), .row_idx(ls_row_idx));

  int nchk = 0, npass = 0, cyc = 0, xfers = 0, lasts = 0, exp_idx = 0;
  coef_row_t q[$];
  coef_row_t cur_exp;
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic pix_t pk_in(input int v[N]);
    pix_t r;
    for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = v[i][IN_W-1:0];
    return r;
  endfunction

  function automatic coef_row_t pk_out(input int v[N]);
    coef_row_t r;
    for (int i = 0; i < N; i++) r[i*OUT_W +: OUT_W] = v[i][OUT_W-1:0];
    return r;
  endfunction

  // Reference: repeated pairwise sum/difference on a shrinking low band (signed input).
  function automatic coef_row_t haar_ref(input pix_t p);
    int a[N];
    int t[N];
    int len;
    for (int i = 0; i < N; i++) a[i] = int'($signed(p[i*IN_W +: IN_W]));
    len = N;
    while (len > 1) begin
      t = a;
      for (int i = 0; i < len/2; i++) begin
        int s, d;
        s = a[2*i] + a[2*i+1];
        d = a[2*i] - a[2*i+1];
`ifdef HAAR_SCALE_EN
        s = (s + 1) >>> 1;
        d = (d + 1) >>> 1;
`endif
        t[i] = s;
        t[len/2+i] = d;
      end
      a = t;
      len = len / 2;
    end
    return pk_out(a);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nchk++;
          $display("FAIL sb_empty: got row %0h required no output", out_data);
        end else chk("out_data", out_data, q.pop_front());
        chk("row_idx", row_idx, exp_idx);
        chk("out_last", out_last, exp_idx == ROWS-1);
        if (out_last) lasts++;
        exp_idx = (exp_idx == ROWS-1) ? 0 : exp_idx + 1;
        xfers++;
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic send(input pix_t p, input coef_row_t e);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = p;
    cur_exp = e;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      nchk++;
      $display("FAIL send_timeout: got no accept required accept");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    exp_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t ls_tbl[4];
    int a[N];
    int e[N];
    pix_t rows[12];
    int x0, c0, lat, stalls, quiet;
    bit seen, stable;
    coef_row_t snap;

    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cur_exp = '0;
    ls_in_valid = 1'b0; ls_in_data = '0; ls_out_ready = 1'b1;

    a = '{0, 1, 2, 3, 4, 5, 6, 7};
`ifdef HAAR_SCALE_EN
    e = '{4, -2, -1, -1, 0, 0, 0, 0};
`else
    e = '{28, -16, -4, -4, -1, -1, -1, -1};
`endif
    tbl[0].pix = pk_in(a); tbl[0].exp = pk_out(e);
    a = '{0, 0, 0, 0, 0, 0, 0, 0};
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].pix = pk_in(a); tbl[1].exp = pk_out(e);
    a = '{10, 10, 10, 10, 10, 10, 10, 10};
`ifdef HAAR_SCALE_EN
    e = '{10, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{80, 0, 0, 0, 0, 0, 0, 0};
`endif
    tbl[2].pix = pk_in(a); tbl[2].exp = pk_out(e);
    a = '{-128, -128, -128, -128, -128, -128, -128, -128};
`ifdef HAAR_SCALE_EN
    e = '{-128, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{-1024, 0, 0, 0, 0, 0, 0, 0};
`endif
    tbl[3].pix = pk_in(a); tbl[3].exp = pk_out(e);
    a = '{127, 127, 127, 127, 127, 127, 127, 127};
`ifdef HAAR_SCALE_EN
    e = '{127, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{1016, 0, 0, 0, 0, 0, 0, 0};
`endif
    tbl[4].pix = pk_in(a); tbl[4].exp = pk_out(e);
    a = '{127, -128, 127, -128, 127, -128, 127, -128};
`ifdef HAAR_SCALE_EN
    e = '{0, 0, 0, 0, 128, 128, 128, 128};
`else
    e = '{-4, 0, 0, 0, 255, 255, 255, 255};
`endif
    tbl[5].pix = pk_in(a); tbl[5].exp = pk_out(e);

    a = '{138, 138, 138, 138, 138, 138, 138, 138};
`ifdef HAAR_SCALE_EN
    e = '{10, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{80, 0, 0, 0, 0, 0, 0, 0};
`endif
    ls_tbl[0].pix = pk_in(a); ls_tbl[0].exp = pk_out(e);
    a = '{128, 128, 128, 128, 128, 128, 128, 128};
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    ls_tbl[1].pix = pk_in(a); ls_tbl[1].exp = pk_out(e);
    a = '{255, 255, 255, 255, 255, 255, 255, 255};
`ifdef HAAR_SCALE_EN
    e = '{127, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{1016, 0, 0, 0, 0, 0, 0, 0};
`endif
    ls_tbl[2].pix = pk_in(a); ls_tbl[2].exp = pk_out(e);
    a = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef HAAR_SCALE_EN
    e = '{-128, 0, 0, 0, 0, 0, 0, 0};
`else
    e = '{-1024, 0, 0, 0, 0, 0, 0, 0};
`endif
    ls_tbl[3].pix = pk_in(a); ls_tbl[3].exp = pk_out(e);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ls_out_valid", ls_out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Table vectors, signed input, free-flowing output
    for (int i = 0; i < 6; i++) send(tbl[i].pix, tbl[i].exp);
    in_valid = 1'b0;
    drain();

    // Level-shifted instance, single rows with latency check
    for (int i = 0; i < 4; i++) begin
      ls_in_valid = 1'b1;
      ls_in_data = ls_tbl[i].pix;
      @(posedge clk);
      #1;
      ls_in_valid = 1'b0;
      lat = 1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (ls_out_valid) seen = 1'b1;
        else begin
          @(posedge clk);
          lat++;
        end
      end
      chk("ls_latency", lat, 3);
      chk("ls_out_data", ls_out_data, ls_tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // 16 back-to-back rows with random output stalls
    do_reset();
    lasts = 0;
    x0 = xfers;
    rand_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      pix_t p;
      p = {$urandom, $urandom};
      send(p, haar_ref(p));
    end
    in_valid = 1'b0;
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    chk("blk_lasts", lasts, 2);
    chk("blk_count", xfers - x0, 16);
    chk("blk_row_idx_wrap", row_idx, 0);

    // Fill pipe under stall, hold, then release and stream
    do_reset();
    for (int k = 0; k < 12; k++) rows[k] = {$urandom, $urandom};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(rows[k], haar_ref(rows[k]));
    in_valid = 1'b1;
    in_data = rows[3];
    cur_exp = haar_ref(rows[3]);
    stalls = 0;
    stable = 1'b1;
    snap = '0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t == 0) snap = out_data;
      if (!in_ready) stalls++;
      if (out_data !== snap || !out_valid) stable = 1'b0;
    end
    chk("stall_in_ready_low", stalls, 10);
    chk("stall_data_stable", stable, 1);
    chk("stall_head_row", out_data, haar_ref(rows[0]));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    x0 = xfers;
    c0 = cyc;
    for (int k = 3; k < 12; k++) send(rows[k], haar_ref(rows[k]));
    chk("stream_cycles", cyc - c0, 9);
    chk("stream_xfers", xfers - x0, 9);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with rows in flight
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pix_t p;
      p = {$urandom, $urandom};
      send(p, haar_ref(p));
    end
    in_valid = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1);
    chk("pre_reset_row_idx", row_idx, 2);
    #2;
    rst_n = 1'b0;
    q.delete();
    exp_idx = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_row_idx", row_idx, 0);
    chk("mid_rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (!out_valid) quiet++;
    end
    chk("post_rst_quiet", quiet, 5);
    @(posedge clk);
    #1;
    x0 = xfers;
    send(tbl[0].pix, tbl[0].exp);
    in_valid = 1'b0;
    drain();
    chk("post_rst_xfers", xfers - x0, 1);
    chk("post_rst_row_idx", row_idx, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
